// File: rtl/bypass_fifo.sv
// Bypass FIFO: enqueue is ordered before dequeue within a cycle, so a word
// written into an empty FIFO appears on the dequeue side in the same cycle.

module bypass_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enq_en,
    input  logic [N-1:0]               enq_data,
    output logic                       enq_rdy,
    input  logic                       deq_en,
    output logic [N-1:0]               deq_data,
    output logic                       deq_rdy,
    input  logic                       clear,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [N-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_wptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_enq_fire;
    logic w_deq_fire;
    logic w_push;
    logic w_pop;

    // Wrap by explicit compare so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign w_empty    = (r_count == '0);
    assign enq_rdy    = (r_count != FULL_CNT);
    assign w_enq_fire = enq_en & enq_rdy;
    assign deq_rdy    = ~w_empty | w_enq_fire;
    assign w_deq_fire = deq_en & deq_rdy;
    assign deq_data   = w_empty ? enq_data : r_mem[r_rptr];

    // A dequeue on an empty FIFO consumes the bypassed word, so nothing is stored or popped.
    assign w_push = w_enq_fire & ~(w_deq_fire & w_empty);
    assign w_pop  = w_deq_fire & ~w_empty;

    assign count = r_count;

    // NOTE: storage has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= enq_data;
        end
    end

    // Clear is evaluated last and overrides the same-cycle enqueue/dequeue updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bypass_fifo.sv
// Scoreboard bench for bypass_fifo: a DEPTH=2 and a DEPTH=4 instance driven
// with directed vectors; monitors pop expected words on every dequeue fire.

module tb_bypass_fifo;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       enq_en2, deq_en2, clear2, enq_rdy2, deq_rdy2;
    logic [7:0] enq_data2, deq_data2;
    logic [1:0] count2;

    logic       enq_en4, deq_en4, clear4, enq_rdy4, deq_rdy4;
    logic [7:0] enq_data4, deq_data4;
    logic [2:0] count4;

    bypass_fifo #(.N(8), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .enq_en(enq_en2), .enq_data(enq_data2), .enq_rdy(enq_rdy2),
        .deq_en(deq_en2), .deq_data(deq_data2), .deq_rdy(deq_rdy2),
        .clear(clear2), .count(count2)
    );

    bypass_fifo #(.N(8), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .enq_en(enq_en4), .enq_data(enq_data4), .enq_rdy(enq_rdy4),
        .deq_en(deq_en4), .deq_data(deq_data4), .deq_rdy(deq_rdy4),
        .clear(clear4), .count(count4)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] q2[$];
    logic [7:0] q4[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
    task automatic cyc2(input logic enq, input logic [7:0] d, input logic deq, input logic clr);
        @(posedge clk);
        #1;
        enq_en2 = enq; enq_data2 = d; deq_en2 = deq; clear2 = clr;
        #2;
    endtask

    task automatic cyc4(input logic enq, input logic [7:0] d, input logic deq, input logic clr);
        @(posedge clk);
        #1;
        enq_en4 = enq; enq_data4 = d; deq_en4 = deq; clear4 = clr;
        #2;
    endtask

    always @(negedge clk) begin
        if (rst_n && deq_en2 && deq_rdy2) begin
            check("dut2_deq_expected", 32'(q2.size() != 0), 32'd1);
            if (q2.size() != 0) check("dut2_deq_data", 32'(deq_data2), 32'(q2.pop_front()));
        end
        if (rst_n && deq_en4 && deq_rdy4) begin
            check("dut4_deq_expected", 32'(q4.size() != 0), 32'd1);
            if (q4.size() != 0) check("dut4_deq_data", 32'(deq_data4), 32'(q4.pop_front()));
        end
    end

    initial begin
        rst_n = 1'b0;
        enq_en2 = 1'b1; enq_data2 = 8'hA5; deq_en2 = 1'b0; clear2 = 1'b0;
        enq_en4 = 1'b0; enq_data4 = 8'h00; deq_en4 = 1'b0; clear4 = 1'b0;

        // Reset with an enqueue request pending: passthrough visible.
        repeat (3) @(posedge clk);
        #3;
        check("rst_enq_rdy", 32'(enq_rdy2), 32'd1);
        check("rst_count", 32'(count2), 32'd0);
        check("rst_deq_rdy", 32'(deq_rdy2), 32'd1);
        check("rst_deq_data", 32'(deq_data2), 32'hA5);
        check("rst_count4", 32'(count4), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        enq_en2 = 1'b0;
        cyc2(1'b0, 8'h00, 1'b0, 1'b0);
        check("post_rst_count", 32'(count2), 32'd0);
        check("post_rst_deq_rdy", 32'(deq_rdy2), 32'd0);

        // Bypass on empty.
        q2.push_back(8'h3C);
        cyc2(1'b1, 8'h3C, 1'b1, 1'b0);
        check("bypass_deq_data", 32'(deq_data2), 32'h3C);
        check("bypass_deq_rdy", 32'(deq_rdy2), 32'd1);
        cyc2(1'b0, 8'h00, 1'b0, 1'b0);
        check("bypass_count", 32'(count2), 32'd0);
        check("bypass_deq_rdy_after", 32'(deq_rdy2), 32'd0);

        // Fill, full and wrap on DEPTH=2.
        cyc2(1'b1, 8'h11, 1'b0, 1'b0);
        cyc2(1'b1, 8'h22, 1'b0, 1'b0);
        check("fill_count1", 32'(count2), 32'd1);
        cyc2(1'b1, 8'h33, 1'b0, 1'b0);
        check("full_count", 32'(count2), 32'd2);
        check("full_enq_rdy", 32'(enq_rdy2), 32'd0);
        cyc2(1'b0, 8'h00, 1'b0, 1'b0);
        check("full_ignored_count", 32'(count2), 32'd2);
        check("full_head", 32'(deq_data2), 32'h11);
        q2.push_back(8'h11);
        cyc2(1'b1, 8'h33, 1'b1, 1'b0);
        check("full_deq_enq_refused", 32'(enq_rdy2), 32'd0);
        q2.push_back(8'h22);
        cyc2(1'b1, 8'h33, 1'b1, 1'b0);
        check("after_full_deq_count", 32'(count2), 32'd1);
        check("mid_enq_rdy", 32'(enq_rdy2), 32'd1);
        q2.push_back(8'h33);
        cyc2(1'b0, 8'h00, 1'b1, 1'b0);
        check("simul_count", 32'(count2), 32'd1);
        cyc2(1'b0, 8'h00, 1'b0, 1'b0);
        check("wrap_drain_count", 32'(count2), 32'd0);

        // Simultaneous enq/deq at mid occupancy on DEPTH=4.
        cyc4(1'b1, 8'h01, 1'b0, 1'b0);
        cyc4(1'b1, 8'h02, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            q4.push_back(8'(i + 1));
            cyc4(1'b1, 8'(i + 3), 1'b1, 1'b0);
            check("mid_occ_count", 32'(count4), 32'd2);
        end
        cyc4(1'b0, 8'h00, 1'b0, 1'b0);
        check("mid_occ_count_end", 32'(count4), 32'd2);

        // Clear has lowest priority; the old head still dequeues that cycle.
        q4.push_back(8'h05);
        cyc4(1'b1, 8'h77, 1'b1, 1'b1);
        check("clear_head", 32'(deq_data4), 32'h05);
        cyc4(1'b0, 8'h00, 1'b0, 1'b0);
        check("clear_count", 32'(count4), 32'd0);
        check("clear_enq_rdy", 32'(enq_rdy4), 32'd1);
        check("clear_deq_rdy", 32'(deq_rdy4), 32'd0);

        // Async reset between edges with three entries stored.
        cyc4(1'b1, 8'hAA, 1'b0, 1'b0);
        cyc4(1'b1, 8'hBB, 1'b0, 1'b0);
        cyc4(1'b1, 8'hCC, 1'b0, 1'b0);
        cyc4(1'b0, 8'h00, 1'b0, 1'b0);
        check("pre_areset_count", 32'(count4), 32'd3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("areset_count", 32'(count4), 32'd0);
        check("areset_enq_rdy", 32'(enq_rdy4), 32'd1);
        #1;
        rst_n = 1'b1;
        cyc4(1'b1, 8'h44, 1'b0, 1'b0);
        cyc4(1'b1, 8'h55, 1'b0, 1'b0);
        q4.push_back(8'h44);
        cyc4(1'b0, 8'h00, 1'b1, 1'b0);
        check("areset_refill_count", 32'(count4), 32'd2);
        q4.push_back(8'h55);
        cyc4(1'b0, 8'h00, 1'b1, 1'b0);
        cyc4(1'b0, 8'h00, 1'b0, 1'b0);
        check("areset_drain_count", 32'(count4), 32'd0);

        @(posedge clk);
        #1;
        check("q2_drained", 32'(q2.size()), 32'd0);
        check("q4_drained", 32'(q4.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bypass_fifo.md
# bypass_fifo

Parameterised bypass FIFO for the FIFO library. Its ordering is enqueue-before-dequeue within a cycle, so a word enqueued into an empty FIFO is visible on the dequeue side in the same cycle. The write side of each cycle takes effect before the read side, and a synchronous clear is applied last. It is the bypass complement of the pipeline FIFO and sits on latency-critical links between pipeline stages.

## Interface
- N, 8, data width in bits
- DEPTH, 2, number of storage entries (≥1, need not be a power of two)
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- enq_en  input  1  enqueue request; accepted only when enq_rdy=1
- enq_data  input  N  word to enqueue
- enq_rdy  output  1  FIFO not full
- deq_en  input  1  dequeue request; accepted only when deq_rdy=1
- deq_data  output  N  word at head, or bypassed enq_data
- deq_rdy  output  1  FIFO not empty, or an enqueue is in progress this cycle
- clear  input  1  synchronous flush to empty, lowest priority
- count  output  $clog2(DEPTH+1)  number of stored entries (registered)

## Operation
**State**
- Storage array mem[DEPTH] of N bits.
- Read pointer rptr and write pointer wptr, each in 0..DEPTH-1.
- Registered count.
- Pointers wrap from DEPTH-1 to 0. Wrap is by explicit compare, not modulo-2^k.

**Combinational outputs**
- enq_rdy = (count != DEPTH). It depends only on registered state and has no combinational path from any input.
- enq_fire = enq_en & enq_rdy.
- deq_rdy = (count != 0) | enq_fire.
- deq_data = mem[rptr] when count != 0, else enq_data.
- deq_fire = deq_en & deq_rdy.

**Next-state rules**, evaluated in order enq → deq → clear:
- Requests made while not ready are ignored: no state change and no error.
- enq_fire only: mem[wptr] ← enq_data, wptr advances, count+1.
- deq_fire only: rptr advances, count−1. mem contents are not cleared.
- Both fire, count==0 (bypass): the word passes through combinationally. mem, pointers and count are unchanged.
- Both fire, 0<count<DEPTH: write at wptr and read at rptr. Both pointers advance and count is unchanged.
- Both fire, count==DEPTH: cannot occur, because enq_rdy=0.
- clear=1: rptr, wptr and count go to 0 at the edge, overriding any enq/deq effect in the same cycle.
  - Same-cycle handshakes still complete from the producer's and consumer's view: enq_rdy, deq_rdy and deq_data are computed as above.
  - A bypassed word is delivered.
  - A word enqueued into storage in that cycle is discarded.

**Reset**
- rst_n low forces rptr=0, wptr=0, count=0 immediately, regardless of clk.
- mem is not reset.
- Reset asserted mid-operation discards all contents.

## Timing
**Reset values**
- enq_rdy=1.
- count=0.
- deq_rdy = enq_en (0 when no enqueue is requested).
- deq_data = enq_data (passthrough, since count=0).

**Latency**
- Enqueue to dequeue visibility is 0 cycles when the FIFO is empty (bypass), via a combinational path enq_en/enq_data → deq_rdy/deq_data.
- Otherwise a word is visible once all older entries have been dequeued.

**Other timing rules**
- count, enq_rdy and pointer updates take effect in the cycle after the fire.
- Throughput is one enq and one deq per cycle sustained at any occupancy below DEPTH.
- At full occupancy, no enqueue is accepted that cycle even if a deq fires. This is the defining bypass-FIFO restriction, and the verifier checks it explicitly.
- DEPTH=1 behaviour:
  - Empty state: pass-through.
  - A stored word blocks enq until it is dequeued.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles with enq_en=1, enq_data=8'hA5 → enq_rdy=1, count=0, deq_rdy=1, deq_data=8'hA5. Release rst_n → count=0 until an edge with enq_fire.
- **Bypass on empty:** count=0, drive enq_en=1 and deq_en=1 with 8'h3C → same-cycle deq_data=8'h3C and deq_rdy=1. Next cycle count=0 and deq_rdy=0 with enq_en=0.
- **Fill, full and wrap (DEPTH=2):**
  - Enqueue 8'h11, then 8'h22 → count=2, enq_rdy=0.
  - Enqueue 8'h33 while full → ignored.
  - Then drive deq_en=1 and enq_en=1 for 8'h33 together → deq yields 8'h11, enq refused (enq_rdy=0), count=1.
  - Then enq 8'h33 with deq → deq yields 8'h22 and count stays 1.
  - Then deq yields 8'h33 (wptr has wrapped), count=0.
- **Simultaneous mid-occupancy:** DEPTH=4, preload 8'h01, 8'h02. Run 4 cycles of enq (8'h03..8'h06) with deq → outputs 8'h01..8'h04, count stays 2 throughout.
- **Clear priority:** count=2, one cycle with clear=1, enq_en=1 (8'h77) and deq_en=1 → deq_data equals the old head that cycle. Next cycle count=0, enq_rdy=1 and deq_rdy=0 with enq_en=0.
- **Async reset mid-operation:** with count=3, pulse rst_n low between clock edges → count=0 and enq_rdy=1 immediately, before the next edge. Words enqueued after reset is released dequeue in order and return none of the old data.
